// File: rtl/upsample_layer_sched_pkg.sv
// Shared definitions for the upsample layer sequencer: field widths, channel alignment, FSM states.
// No logic. Widths match the upsampling engine's config registers.
// Imported by the sequencer top and its descriptor queue.
package upsample_layer_sched_pkg;

    localparam int UPS_ROW_W         = 11;
    localparam int UPS_CH_W          = 10;
    localparam int UPS_TAG_W         = 4;
    // The engine processes channels in groups of 16, so the low 4 bits must be zero.
    localparam int UPS_CH_ALIGN_BITS = 4;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_CHECK  = 4'd2,
        ST_NEXT   = 4'd3,
        ST_SETTLE = 4'd4,
        ST_START  = 4'd5,
        ST_RUN    = 4'd6,
        ST_DONE   = 4'd7
    } sched_state_t;

endpackage

// File: rtl/upsample_layer_sched_cmd_fifo.sv
// ups_cmd_fifo: synchronous descriptor queue, DEPTH entries, head visible combinationally on pop_dat.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: push_rdy is registered, so a pop on a full queue frees the slot only the next cycle.
module ups_cmd_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop, full_nxt;

    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    // Extra pointer MSB separates full from empty; pointers wrap by natural overflow.
    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                        (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    assign empty      = (wr_ptr == rd_ptr);
    assign pop_dat    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            push_rdy <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            push_rdy <= !full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/upsample_layer_sched.sv
// Layer sequencer for the 2x upsampling engine; UPS_SCHED_PERF_EN adds RUN-cycle and layer counters.
// Latency: Next_Reg 3 cycles after push, Start SETTLE_CYCLES+1 later, done_pulse 2 after completion.
// Backpressure: cmd_ready drops while the descriptor queue is full; pushes then are not taken.
module upsample_layer_sched
    import upsample_layer_sched_pkg::*;
#(
    parameter int CMD_DEPTH             = 4,
    parameter int WIDTH_FEATURE_SIZE    = UPS_ROW_W,
    parameter int WIDTH_CHANNEL_NUM_REG = UPS_CH_W,
    parameter int TAG_W                 = UPS_TAG_W,
    parameter int SETTLE_CYCLES         = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [WIDTH_FEATURE_SIZE-1:0]    cmd_row,
    input  logic [WIDTH_CHANNEL_NUM_REG-1:0] cmd_channel,
    input  logic [TAG_W-1:0]                 cmd_tag,
    output logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_Out_REG,
    output logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_Out_Num_REG,
    output logic                             Next_Reg,
    output logic                             Start,
    input  logic                             Upsample_Complete,
    output logic                             busy,
    output logic                             done_pulse,
    output logic [TAG_W-1:0]                 done_tag,
    output logic                             err_pulse,
    output logic                             stray_complete
`ifdef UPS_SCHED_PERF_EN
    ,
    output logic [31:0]                      perf_run_cycles,
    output logic [15:0]                      perf_layers
`endif
);

    localparam int DESC_W = WIDTH_FEATURE_SIZE + WIDTH_CHANNEL_NUM_REG + TAG_W;
    localparam int SW     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    sched_state_t                     state;
    logic [SW-1:0]                    settle_cnt;
    logic [WIDTH_FEATURE_SIZE-1:0]    cur_row;
    logic [WIDTH_CHANNEL_NUM_REG-1:0] cur_ch;
    logic [TAG_W-1:0]                 cur_tag;
    logic [DESC_W-1:0]                head_dat;
    logic                             fifo_rdy, fifo_full, fifo_empty;

    ups_cmd_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (cmd_valid && cmd_ready),
        .push_dat ({cmd_row, cmd_channel, cmd_tag}),
        .push_rdy (fifo_rdy),
        .pop      (state == ST_LOAD),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign cmd_ready = fifo_rdy && !fifo_full;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= ST_IDLE;
            settle_cnt          <= '0;
            cur_row             <= '0;
            cur_ch              <= '0;
            cur_tag             <= '0;
            Row_Num_Out_REG     <= '0;
            Channel_Out_Num_REG <= '0;
            Next_Reg            <= 1'b0;
            Start               <= 1'b0;
            done_pulse          <= 1'b0;
            done_tag            <= '0;
            err_pulse           <= 1'b0;
            stray_complete      <= 1'b0;
        end else begin
            Next_Reg   <= 1'b0;
            Start      <= 1'b0;
            done_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            if (Upsample_Complete && state != ST_RUN) begin
                stray_complete <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    {cur_row, cur_ch, cur_tag} <= head_dat;
                    state                      <= ST_CHECK;
                end
                ST_CHECK: begin
                    // A rejected layer leaves the engine config untouched.
                    if (cur_row == '0 || cur_ch == '0 ||
                        cur_ch[UPS_CH_ALIGN_BITS-1:0] != '0) begin
                        err_pulse <= 1'b1;
                        done_tag  <= cur_tag;
                        state     <= ST_IDLE;
                    end else begin
                        Row_Num_Out_REG     <= cur_row;
                        Channel_Out_Num_REG <= cur_ch;
                        Next_Reg            <= 1'b1;
                        state               <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    settle_cnt <= '0;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                        Start <= 1'b1;
                        state <= ST_START;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                ST_START: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (Upsample_Complete) state <= ST_DONE;
                end
                ST_DONE: begin
                    done_pulse <= 1'b1;
                    done_tag   <= cur_tag;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef UPS_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_run_cycles <= '0;
            perf_layers     <= '0;
        end else begin
            if (state == ST_RUN && perf_run_cycles != '1) begin
                perf_run_cycles <= perf_run_cycles + 32'd1;
            end
            if (state == ST_DONE) begin
                perf_layers <= perf_layers + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_upsample_layer_sched.sv
// Directed self-checking bench for upsample_layer_sched (default parameters).
// Build with +define+UPS_SCHED_PERF_EN to also exercise the performance counters.
module tb_upsample_layer_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] cmd_row;
    logic [9:0]  cmd_channel;
    logic [3:0]  cmd_tag;
    logic [10:0] Row_Num_Out_REG;
    logic [9:0]  Channel_Out_Num_REG;
    logic        Next_Reg;
    logic        Start;
    logic        Upsample_Complete;
    logic        busy;
    logic        done_pulse;
    logic [3:0]  done_tag;
    logic        err_pulse;
    logic        stray_complete;
`ifdef UPS_SCHED_PERF_EN
    logic [31:0] perf_run_cycles;
    logic [15:0] perf_layers;
`endif

    upsample_layer_sched dut (
        .clk                 (clk),
        .rst                 (rst),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_row             (cmd_row),
        .cmd_channel         (cmd_channel),
        .cmd_tag             (cmd_tag),
        .Row_Num_Out_REG     (Row_Num_Out_REG),
        .Channel_Out_Num_REG (Channel_Out_Num_REG),
        .Next_Reg            (Next_Reg),
        .Start               (Start),
        .Upsample_Complete   (Upsample_Complete),
        .busy                (busy),
        .done_pulse          (done_pulse),
        .done_tag            (done_tag),
        .err_pulse           (err_pulse),
        .stray_complete      (stray_complete)
`ifdef UPS_SCHED_PERF_EN
        ,
        .perf_run_cycles     (perf_run_cycles),
        .perf_layers         (perf_layers)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nr_cnt = 0, st_cnt = 0, dn_cnt = 0, er_cnt = 0;
    int push_cyc, nr_cyc, st_cyc, cplt_cyc;
    int snap_nr, snap_st, snap_dn;
    logic [3:0] done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (Next_Reg)   nr_cnt++;
        if (Start)      st_cnt++;
        if (err_pulse)  er_cnt++;
        if (done_pulse) begin
            dn_cnt++;
            done_q.push_back(done_tag);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; holds the descriptor until accepted, returns at the following negedge.
    task automatic push(input int row, input int ch, input int tag);
        int n = 0;
        cmd_valid   = 1'b1;
        cmd_row     = 11'(row);
        cmd_channel = 10'(ch);
        cmd_tag     = 4'(tag);
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("push_accepted", 32'(n < 500), 1);
        push_cyc = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_next();
        int n = 0;
        while (!Next_Reg && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("next_seen", 32'(Next_Reg), 1);
        nr_cyc = cyc;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!Start && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 32'(Start), 1);
        st_cyc = cyc;
    endtask

    // Raises Upsample_Complete after n cycles, so RUN lasts exactly n cycles when called at Start.
    task automatic finish_layer(input int n);
        int w = 0;
        repeat (n) @(negedge clk);
        Upsample_Complete = 1'b1;
        cplt_cyc = cyc;
        @(negedge clk);
        Upsample_Complete = 1'b0;
        while (!done_pulse && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("done_seen", 32'(done_pulse), 1);
    endtask

    task automatic run_layer(input int n);
        wait_start();
        finish_layer(n);
    endtask

    task automatic wait_err();
        int n = 0;
        while (!err_pulse && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("err_seen", 32'(err_pulse), 1);
    endtask

    int bad_row[3] = '{8, 0, 8};
    int bad_ch[3]  = '{24, 32, 0};
    int bad_tag[3] = '{7, 9, 10};

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_row = '0;
        cmd_channel = '0;
        cmd_tag = '0;
        Upsample_Complete = 1'b0;
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_next", 32'(Next_Reg), 0);
        chk("rst_start", 32'(Start), 0);
        chk("rst_done", 32'(done_pulse), 0);
        chk("rst_err", 32'(err_pulse), 0);
        chk("rst_stray", 32'(stray_complete), 0);
        chk("rst_row", 32'(Row_Num_Out_REG), 0);
        chk("rst_ch", 32'(Channel_Out_Num_REG), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 32'(cmd_ready), 1);

        // Single layer: latencies and config
        push(20, 64, 3);
        wait_next();
        chk("next_lat", 32'(nr_cyc - push_cyc), 3);
        chk("cfg_row", 32'(Row_Num_Out_REG), 20);
        chk("cfg_ch", 32'(Channel_Out_Num_REG), 64);
        wait_start();
        chk("start_lat", 32'(st_cyc - nr_cyc), 5);
        finish_layer(50);
        chk("done_lat", 32'(cyc - cplt_cyc), 2);
        chk("done_tag1", 32'(done_tag), 3);
        #1;
        chk("t1_next_cnt", 32'(nr_cnt), 1);
        chk("t1_start_cnt", 32'(st_cnt), 1);
        chk("t1_done_cnt", 32'(dn_cnt), 1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done_pulse), 0);

        // Rejected descriptors leave config alone, then a good one runs
        for (int i = 0; i < 3; i++) begin
            push(bad_row[i], bad_ch[i], bad_tag[i]);
            wait_err();
            chk("err_tag", 32'(done_tag), 32'(bad_tag[i]));
            chk("err_keep_row", 32'(Row_Num_Out_REG), 20);
            chk("err_keep_ch", 32'(Channel_Out_Num_REG), 64);
        end
        push(10, 32, 8);
        run_layer(10);
        chk("t3_done_tag", 32'(done_tag), 8);
        chk("t3_row", 32'(Row_Num_Out_REG), 10);
        chk("t3_ch", 32'(Channel_Out_Num_REG), 32);
        #1;
        chk("t3_err_cnt", 32'(er_cnt), 3);
        chk("t3_next_cnt", 32'(nr_cnt), 2);
        @(negedge clk);

        // Stray completions in IDLE and SETTLE
        repeat (3) @(negedge clk);
        chk("stray_before", 32'(stray_complete), 0);
        snap_dn = dn_cnt;
        Upsample_Complete = 1'b1;
        @(negedge clk);
        Upsample_Complete = 1'b0;
        @(negedge clk);
        chk("stray_idle", 32'(stray_complete), 1);
        chk("stray_idle_busy", 32'(busy), 0);
        push(16, 16, 5);
        wait_next();
        @(negedge clk);
        Upsample_Complete = 1'b1;
        @(negedge clk);
        Upsample_Complete = 1'b0;
        wait_start();
        chk("stray_settle_start_lat", 32'(st_cyc - nr_cyc), 5);
        chk("stray_no_done", 32'(dn_cnt - snap_dn), 0);
        finish_layer(5);
        chk("stray_layer_tag", 32'(done_tag), 5);
        @(negedge clk);

        // Queue fill while a layer runs, drop on full, in-order completion
        done_q.delete();
        push(30, 16, 0);
        wait_start();
        push(30, 16, 1);
        push(30, 16, 2);
        push(30, 16, 3);
        chk("ready_three_queued", 32'(cmd_ready), 1);
        push(30, 16, 4);
        chk("ready_full", 32'(cmd_ready), 0);
        cmd_valid = 1'b1;
        cmd_row = 11'd30;
        cmd_channel = 10'd16;
        cmd_tag = 4'd15;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        chk("ready_still_full", 32'(cmd_ready), 0);
        finish_layer(20);
        for (int t = 1; t < 5; t++) run_layer(20);
        repeat (40) @(negedge clk);
        chk("q_count", 32'(done_q.size()), 5);
        for (int t = 0; t < 5; t++) begin
            if (t < done_q.size()) chk("q_order", 32'(done_q[t]), 32'(t));
        end
        chk("q_idle_busy", 32'(busy), 0);

        // Asynchronous reset in RUN with two queued
        push(12, 16, 10);
        wait_start();
        push(12, 16, 11);
        push(12, 16, 12);
        #3 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(cmd_ready), 0);
        chk("arst_tag", 32'(done_tag), 0);
        chk("arst_row", 32'(Row_Num_Out_REG), 0);
        chk("arst_ch", 32'(Channel_Out_Num_REG), 0);
        chk("arst_stray", 32'(stray_complete), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        snap_nr = nr_cnt;
        snap_st = st_cnt;
        snap_dn = dn_cnt;
        repeat (60) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_ready", 32'(cmd_ready), 1);
        chk("post_rst_next", 32'(nr_cnt - snap_nr), 0);
        chk("post_rst_start", 32'(st_cnt - snap_st), 0);
        chk("post_rst_done", 32'(dn_cnt - snap_dn), 0);

`ifdef UPS_SCHED_PERF_EN
        chk("perf_rst_cycles", perf_run_cycles, 0);
        chk("perf_rst_layers", 32'(perf_layers), 0);
        push(8, 16, 1);
        run_layer(40);
        @(negedge clk);
        push(8, 16, 2);
        run_layer(60);
        chk("perf_run_cycles", perf_run_cycles, 100);
        chk("perf_layers", 32'(perf_layers), 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
